// File: rtl/reg_file_pkg.sv
// Shared register-file types for decode and writeback.
//   DATA_W     : register width
//   ADDR_W     : register address width
//   NUM_REGS   : number of architectural registers (2**ADDR_W)
//   reg_addr_t : register index
//   reg_data_t : register contents
package reg_file_pkg;
  localparam int DATA_W   = 8;
  localparam int ADDR_W   = 3;
  localparam int NUM_REGS = 2 ** ADDR_W;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] reg_data_t;
endpackage

// File: rtl/reg_file.sv
// General-purpose register file: 2**ADDR_W registers of DATA_W bits,
// two combinational read ports, one write port committed on rising clk.
//   clk        : clock, writes on rising edge
//   reset      : asynchronous active-high, clears every register
//   read_addr1 : read port 1 select      -> read_val1
//   read_addr2 : read port 2 select      -> read_val2
//   write_addr : write port select
//   write_val  : write data
//   wr_en      : write enable, sampled at the rising edge
// No write-to-read bypass: a read of the write target shows the old value
// until the capturing edge. Register 0 is an ordinary register.
module reg_file #(
  parameter int DATA_W = reg_file_pkg::DATA_W,
  parameter int ADDR_W = reg_file_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] read_addr1,
  input  logic [ADDR_W-1:0] read_addr2,
  input  logic [ADDR_W-1:0] write_addr,
  input  logic [DATA_W-1:0] write_val,
  input  logic              wr_en,
  output logic [DATA_W-1:0] read_val1,
  output logic [DATA_W-1:0] read_val2
);
  import reg_file_pkg::*;

  localparam int N_REGS = 2 ** ADDR_W;

  logic [N_REGS-1:0][DATA_W-1:0] regs;

  // Reset clears without a clock and overrides any write on the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)      regs             <= '0;
    else if (wr_en) regs[write_addr] <= write_val;
  end

  assign read_val1 = regs[read_addr1];
  assign read_val2 = regs[read_addr2];
endmodule

// File: tb/tb_reg_file.sv
module tb_reg_file;
  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] read_addr1, read_addr2, write_addr;
  logic [7:0] write_val;
  logic       wr_en;
  logic [7:0] read_val1, read_val2;

  int n_cmp = 0;
  int n_bad = 0;

  reg_file #(.DATA_W(8), .ADDR_W(3)) dut (
    .clk(clk), .reset(reset),
    .read_addr1(read_addr1), .read_addr2(read_addr2),
    .write_addr(write_addr), .write_val(write_val), .wr_en(wr_en),
    .read_val1(read_val1), .read_val2(read_val2)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       we;
    logic [2:0] wa;
    logic [7:0] wv;
    logic [2:0] ra1;
    logic [2:0] ra2;
    logic [7:0] exp1;
    logic [7:0] exp2;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drive inputs at the falling edge, let one rising edge pass, sample 1ns later.
  task automatic do_cycle(input logic we, input logic [2:0] wa, input logic [7:0] wv,
                          input logic [2:0] ra1, input logic [2:0] ra2);
    @(negedge clk);
    wr_en = we; write_addr = wa; write_val = wv;
    read_addr1 = ra1; read_addr2 = ra2;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Write/read table: each row is one edge, then a check of both ports.
    vecs[0] = '{1'b1, 3'd3, 8'd42,  3'd3, 3'd0, 8'd42, 8'd0};   // basic write
    vecs[1] = '{1'b1, 3'd3, 8'd99,  3'd3, 3'd5, 8'd99, 8'd0};   // overwrite
    vecs[2] = '{1'b0, 3'd5, 8'd100, 3'd5, 3'd3, 8'd0,  8'd99};  // write disabled
    vecs[3] = '{1'b1, 3'd0, 8'h11,  3'd0, 3'd3, 8'h11, 8'd99};  // r0 is writable
    vecs[4] = '{1'b1, 3'd2, 8'd10,  3'd2, 3'd2, 8'd10, 8'd10};  // both ports same reg
    vecs[5] = '{1'b0, 3'd2, 8'd55,  3'd2, 3'd0, 8'd10, 8'h11};  // disabled leaves r2

    reset = 1'b1; wr_en = 1'b0; write_addr = '0; write_val = '0;
    read_addr1 = 3'd0; read_addr2 = 3'd1;
    #2;
    check("reset_rd1", read_val1, 8'd0);
    check("reset_rd2", read_val2, 8'd0);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 6; i++) begin
      do_cycle(vecs[i].we, vecs[i].wa, vecs[i].wv, vecs[i].ra1, vecs[i].ra2);
      check($sformatf("vec%0d_rd1", i), read_val1, vecs[i].exp1);
      check($sformatf("vec%0d_rd2", i), read_val2, vecs[i].exp2);
    end

    // Same-cycle read of the write target: old value until the edge.
    @(negedge clk);
    wr_en = 1'b1; write_addr = 3'd2; write_val = 8'd20; read_addr1 = 3'd2;
    #1;
    check("wr_target_before", read_val1, 8'd10);
    @(posedge clk); #1;
    check("wr_target_after", read_val1, 8'd20);

    // Back-to-back writes to r4: each value visible for one cycle.
    do_cycle(1'b1, 3'd4, 8'd1, 3'd4, 3'd2);
    check("b2b_first", read_val1, 8'd1);
    do_cycle(1'b1, 3'd4, 8'd2, 3'd4, 3'd2);
    check("b2b_second", read_val1, 8'd2);
    check("b2b_other", read_val2, 8'd20);

    // r7 = FF, then pulse reset between edges: clears with no clock edge.
    do_cycle(1'b1, 3'd7, 8'hFF, 3'd7, 3'd4);
    check("r7_written", read_val1, 8'hFF);
    @(negedge clk);
    wr_en = 1'b0;
    #1 reset = 1'b1;
    #1;
    check("async_clr_r7", read_val1, 8'd0);
    check("async_clr_r4", read_val2, 8'd0);
    reset = 1'b0;

    // Reset high across an edge discards a pending write.
    @(negedge clk);
    reset = 1'b1; wr_en = 1'b1; write_addr = 3'd6; write_val = 8'd77; read_addr1 = 3'd6;
    @(posedge clk); #1;
    check("reset_dominates", read_val1, 8'd0);
    // First edge after release performs the write.
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    check("post_reset_write", read_val1, 8'd77);

    // Dual-port sweep: ri = i+1, then every address pair concurrently.
    for (int i = 0; i < 8; i++) do_cycle(1'b1, 3'(i), 8'(i + 1), 3'd0, 3'd0);
    @(negedge clk);
    wr_en = 1'b0;
    for (int a = 0; a < 8; a++) begin
      for (int b = 0; b < 8; b++) begin
        read_addr1 = 3'(a); read_addr2 = 3'(b);
        #1;
        check($sformatf("sweep_rd1_%0d_%0d", a, b), read_val1, 8'(a + 1));
        check($sformatf("sweep_rd2_%0d_%0d", a, b), read_val2, 8'(b + 1));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
